// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame FSM encoding and bit-period helper.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period counter: one-cycle tick every CLKS_PER_BIT enabled cycles.
module uart_tx_baud_tick #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_restart,
   input  logic i_en,
   output logic o_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_wrap;

   assign w_wrap = (r_cnt == LAST);
   assign o_tick = i_en && w_wrap;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || !i_en || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Byte-to-serial UART transmitter: start, 8 data bits LSB first, stop bits.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLK_FREQ  = 100000000,
   parameter int BAUD_RATE = 115200,
   parameter int STOP_BITS = 1
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   output logic       tx_o,
   output logic       busy_o
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_tx: CLKS_PER_BIT must be at least 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   tx_state_t  r_state;
   tx_state_t  w_state_nxt;
   logic [7:0] r_shift;
   logic [7:0] w_shift_nxt;
   logic [2:0] r_bit;
   logic [2:0] w_bit_nxt;
   logic       r_tx;
   logic       r_ready;
   logic       r_busy;
   logic       w_tx_nxt;
   logic       w_ready_nxt;
   logic       w_busy_nxt;
   logic       w_tick;
   logic       w_accept;
   logic       w_last_stop;

   assign w_accept    = valid_i && r_ready;
   assign w_last_stop = (r_bit == 3'(STOP_BITS - 1));

   assign ready_o = r_ready;
   assign tx_o    = r_tx;
   assign busy_o  = r_busy;

   uart_tx_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tick (
      .i_clk    (clk_i),
      .i_rst_n  (reset_i),
      .i_restart(w_accept),
      .i_en     (r_state != S_IDLE),
      .o_tick   (w_tick)
   );

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_bit   <= w_bit_nxt;
      end
   end

   // r_bit indexes data bits in DATA and counts stop bits in STOP
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_START;
               w_shift_nxt = data_i;
               w_bit_nxt   = '0;
            end
         end
         S_START: begin
            if (w_tick) w_state_nxt = S_DATA;
         end
         S_DATA: begin
            if (w_tick) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_bit_nxt   = '0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (w_last_stop) begin
                  w_state_nxt = S_IDLE;
                  w_bit_nxt   = '0;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be flopped
   always_comb begin
      w_tx_nxt    = 1'b1;
      w_ready_nxt = 1'b0;
      w_busy_nxt  = 1'b1;
      unique case (w_state_nxt)
         S_IDLE: begin
            w_ready_nxt = 1'b1;
            w_busy_nxt  = 1'b0;
         end
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         S_STOP:  w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_tx    <= 1'b1;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_tx    <= w_tx_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard testbench for uart_tx at 10 clocks per bit, one stop bit.
module tb_uart_tx;

   localparam int CPB   = 10;
   localparam int NBITS = 10;
   localparam int FRAME = NBITS * CPB;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       valid = 1'b0;
   logic       ready;
   logic       tx;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;
   bit exp_q[$];

   uart_tx #(
      .CLK_FREQ (100000000),
      .BAUD_RATE(10000000),
      .STOP_BITS(1)
   ) dut (
      .clk_i  (clk),
      .reset_i(rst_n),
      .data_i (data),
      .valid_i(valid),
      .ready_o(ready),
      .tx_o   (tx),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: time limit reached, passed=%0d total=%0d",
               n_pass, n_total);
      $fatal(1, "watchdog");
   end

   task automatic push_frame(input logic [7:0] b);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(1'b1);
   endtask

   // Records tx per cycle starting at the current negedge
   task automatic observe(output logic [FRAME-1:0] txs,
                          output int nbusy);
      nbusy = 0;
      for (int j = 0; j < FRAME; j++) begin
         txs[j] = tx;
         if (busy === 1'b1 && ready === 1'b0) nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      valid = 1'b1;
      data  = 8'h55;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_total++;
         if (tx === 1'b1 && ready === 1'b0 && busy === 1'b0) n_pass++;
         else $display("FAIL reset_hold%0d: tx=%b ready=%b busy=%b want 1 0 0",
                       i, tx, ready, busy);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (tx === 1'b1 && ready === 1'b1 && busy === 1'b0) n_pass++;
      else $display("FAIL reset_release: tx=%b ready=%b busy=%b want 1 1 0",
                    tx, ready, busy);
      valid = 1'b0;
      repeat (5) @(negedge clk);
      n_total++;
      if (tx === 1'b1 && busy === 1'b0) n_pass++;
      else $display("FAIL reset_nothing_sent: tx=%b busy=%b want 1 0",
                    tx, busy);
   endtask

   task automatic test_single;
      logic [FRAME-1:0] txs;
      int nb;
      bit e;
      bit ok;
      data  = 8'h33;
      valid = 1'b1;
      push_frame(8'h33);
      @(negedge clk);
      valid = 1'b0;
      observe(txs, nb);
      for (int k = 0; k < NBITS; k++) begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         for (int c = 0; c < CPB; c++)
            if (txs[k*CPB+c] !== e) ok = 1'b0;
         n_total++;
         if (ok) n_pass++;
         else $display("FAIL single_bit%0d: tx=%b want all %b",
                       k, txs[k*CPB +: CPB], e);
      end
      n_total++;
      if (nb == FRAME) n_pass++;
      else $display("FAIL single_busy_cycles: got %0d want %0d", nb, FRAME);
      n_total++;
      if (tx === 1'b1 && ready === 1'b1 && busy === 1'b0) n_pass++;
      else $display("FAIL single_idle_after: tx=%b ready=%b busy=%b want 1 1 0",
                    tx, ready, busy);
   endtask

   task automatic test_back_to_back;
      logic [FRAME-1:0] txs1;
      logic [FRAME-1:0] txs2;
      logic idle_tx;
      logic idle_rdy;
      int nb;
      bit e;
      bit ok;
      data  = 8'h33;
      valid = 1'b1;
      push_frame(8'h33);
      push_frame(8'hF0);
      @(negedge clk);
      data = 8'hF0;
      observe(txs1, nb);
      idle_tx  = tx;
      idle_rdy = ready;
      @(negedge clk);
      valid = 1'b0;
      observe(txs2, nb);
      n_total++;
      if (txs1[0] === 1'b0 && idle_tx === 1'b1 && idle_rdy === 1'b1 &&
          txs2[0] === 1'b0) n_pass++;
      else $display("FAIL b2b_gap: start1=%b idle_tx=%b idle_ready=%b start2=%b want 0 1 1 0",
                    txs1[0], idle_tx, idle_rdy, txs2[0]);
      for (int k = 0; k < 2 * NBITS; k++) begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         for (int c = 0; c < CPB; c++) begin
            if (k < NBITS) begin
               if (txs1[k*CPB+c] !== e) ok = 1'b0;
            end else begin
               if (txs2[(k-NBITS)*CPB+c] !== e) ok = 1'b0;
            end
         end
         n_total++;
         if (ok) n_pass++;
         else $display("FAIL b2b_frame%0d_bit%0d: want %b",
                       k / NBITS, k % NBITS, e);
      end
      n_total++;
      if (busy === 1'b0 && ready === 1'b1) n_pass++;
      else $display("FAIL b2b_idle_after: busy=%b ready=%b want 0 1",
                    busy, ready);
   endtask

   task automatic test_data_stability;
      logic [FRAME-1:0] txs;
      int nb;
      bit e;
      bit ok;
      data  = 8'hA5;
      valid = 1'b1;
      push_frame(8'hA5);
      @(negedge clk);
      fork
         observe(txs, nb);
         begin
            data  = 8'h00;
            valid = 1'b0;
            repeat (90) begin
               @(negedge clk);
               valid = ~valid;
            end
            valid = 1'b0;
         end
      join
      for (int k = 0; k < NBITS; k++) begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         for (int c = 0; c < CPB; c++)
            if (txs[k*CPB+c] !== e) ok = 1'b0;
         n_total++;
         if (ok) n_pass++;
         else $display("FAIL stable_bit%0d: tx=%b want all %b",
                       k, txs[k*CPB +: CPB], e);
      end
      ok = 1'b1;
      repeat (30) begin
         if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL stable_no_extra_frame: tx=%b busy=%b want 1 0",
                    tx, busy);
   endtask

   task automatic test_reset_mid_frame;
      logic [FRAME-1:0] txs;
      int nb;
      bit e;
      bit ok;
      data  = 8'hF0;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      repeat (44) @(negedge clk);
      n_total++;
      if (tx === 1'b0 && busy === 1'b1) n_pass++;
      else $display("FAIL midrst_in_bit3: tx=%b busy=%b want 0 1", tx, busy);
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (tx === 1'b1 && busy === 1'b0 && ready === 1'b0) n_pass++;
      else $display("FAIL midrst_abort: tx=%b busy=%b ready=%b want 1 0 0",
                    tx, busy, ready);
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if (ready === 1'b1 && tx === 1'b1) n_pass++;
      else $display("FAIL midrst_ready: ready=%b tx=%b want 1 1", ready, tx);
      data  = 8'h0F;
      valid = 1'b1;
      push_frame(8'h0F);
      @(negedge clk);
      valid = 1'b0;
      observe(txs, nb);
      for (int k = 0; k < NBITS; k++) begin
         e  = exp_q.pop_front();
         ok = 1'b1;
         for (int c = 0; c < CPB; c++)
            if (txs[k*CPB+c] !== e) ok = 1'b0;
         n_total++;
         if (ok) n_pass++;
         else $display("FAIL midrst_bit%0d: tx=%b want all %b",
                       k, txs[k*CPB +: CPB], e);
      end
      n_total++;
      if (nb == FRAME) n_pass++;
      else $display("FAIL midrst_busy_cycles: got %0d want %0d", nb, FRAME);
   endtask

   task automatic test_idle_hold;
      bit ok;
      valid = 1'b0;
      ok    = 1'b1;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      end
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL idle_hold: tx=%b ready=%b busy=%b want 1 1 0",
                    tx, ready, busy);
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL scoreboard_drained: left=%0d want 0", exp_q.size());
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_data_stability();
      test_reset_mid_frame();
      test_idle_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
